fetch_redirect_ctrl: RTL

Sequences all program-counter redirects into the fetch stage of the RISC-V pipeline.
- Redirect sources: EXE-stage branches, JAL/JALR, MRET and external-interrupt entry.
- Drives the fetch next-PC select/target and flushes IF/ID and ID/EX.
- Saves the return PC (mepc) and masks interrupts while a handler runs.
- Sits between the EXE stage, the hazard/stall unit and fetch.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/redirect_mux.sv | 49 ++++
 rtl/fetch_redirect_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types for the fetch redirect controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        ENTER   = 2'd2,
        HANDLER = 2'd3
    } irq_state_t;

    // Which source produced the current redirect; kept for debug/trace.
    typedef enum logic [2:0] {
        RS_NONE   = 3'd0,
        RS_BRANCH = 3'd1,
        RS_JALR   = 3'd2,
        RS_MRET   = 3'd3,
        RS_IRQ    = 3'd4
    } redirect_src_t;

endpackage
`default_nettype wire

// File: rtl/redirect_mux.sv
`default_nettype none
// ============================================================================
//  Module      : redirect_mux
//  Description : Combinational priority select of redirect target and source.
//  Revision    : 1.0 - initial release
// ============================================================================
module redirect_mux
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              irq_enter,
    input  logic              mret,
    input  logic              jalr,
    input  logic              branch,
    input  logic [XLEN-1:0]   irq_vector,
    input  logic [XLEN-1:0]   mepc,
    input  logic [XLEN-1:0]   jalr_target,
    input  logic [XLEN-1:0]   branch_target,
    output logic              valid,
    output logic [XLEN-1:0]   target,
    output redirect_src_t     src
);

    // Interrupt entry lasts a single cycle and must complete, so it outranks
    // any EXE redirect that happens to coincide with it.
    always_comb begin
        valid  = 1'b1;
        target = '0;
        src    = RS_NONE;
        if (irq_enter) begin
            target = irq_vector;
            src    = RS_IRQ;
        end else if (mret) begin
            target = mepc;
            src    = RS_MRET;
        end else if (jalr) begin
            target = {jalr_target[XLEN-1:1], 1'b0};
            src    = RS_JALR;
        end else if (branch) begin
            target = branch_target;
            src    = RS_BRANCH;
        end else begin
            valid  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_ctrl
//  Description : Sequences branch/JAL/JALR/MRET/interrupt redirects into fetch.
//                Optional macro FETCH_IRQ_SYNC_EN adds a 2-flop ext_irq sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_irq,
    input  logic              irq_en,
    input  logic [XLEN-1:0]   irq_vector,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   pc_ID,
    input  logic [XLEN-1:0]   pc_IF,
    input  logic              branch_taken_EXE,
    input  logic [XLEN-1:0]   branch_jump_addr,
    input  logic              pcJalSrc_EXE,
    input  logic [XLEN-1:0]   alu_result_EXE,
    input  logic              mret_EXE,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic [XLEN-1:0]   mepc,
    output logic              in_handler,
    output logic              irq_ack,
    output logic              misalign_err
);

    irq_state_t     r_state;
    irq_state_t     w_state_nxt;
    logic [XLEN-1:0] r_mepc;
    logic           r_in_handler;
    logic           r_misalign;
    logic           w_irq;
    logic           w_exe_redirect;
    logic           w_mux_valid;
    logic [XLEN-1:0] w_mux_target;
    redirect_src_t  w_mux_src;

`ifdef FETCH_IRQ_SYNC_EN
    logic [1:0] r_irq_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_sync <= 2'b00;
        end else begin
            r_irq_sync <= {r_irq_sync[0], ext_irq};
        end
    end

    assign w_irq = r_irq_sync[1];
`else
    assign w_irq = ext_irq;
`endif

    assign w_exe_redirect = mret_EXE | pcJalSrc_EXE | branch_taken_EXE;

    redirect_mux #(
        .XLEN (XLEN)
    ) u_redirect_mux (
        .irq_enter     (r_state == ENTER),
        .mret          (mret_EXE),
        .jalr          (pcJalSrc_EXE),
        .branch        (branch_taken_EXE),
        .irq_vector    (irq_vector),
        .mepc          (r_mepc),
        .jalr_target   (alu_result_EXE),
        .branch_target (branch_jump_addr),
        .valid         (w_mux_valid),
        .target        (w_mux_target),
        .src           (w_mux_src)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_irq && irq_en && !r_in_handler) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                // A request that disappears before entry is simply dropped.
                if (!w_irq) begin
                    w_state_nxt = IDLE;
                end else if (!stall && !w_exe_redirect) begin
                    w_state_nxt = ENTER;
                end
            end
            ENTER: begin
                w_state_nxt = HANDLER;
            end
            HANDLER: begin
                if (mret_EXE) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mepc       <= RESET_VECTOR;
            r_in_handler <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            if (r_state == ENTER) begin
                r_mepc       <= id_valid ? pc_ID : pc_IF;
                r_in_handler <= 1'b1;
            end else if (r_state == HANDLER && mret_EXE) begin
                r_in_handler <= 1'b0;
            end
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
        end
    end

    // Pulse outputs are held quiet while reset is asserted.
    assign redirect_valid = w_mux_valid & ~rst;
    assign redirect_pc    = rst ? '0 : w_mux_target;
    assign flush_IFID     = redirect_valid;
    assign flush_IDEX     = redirect_valid;
    assign irq_ack        = (w_mux_src == RS_IRQ) & ~rst;
    assign mepc           = r_mepc;
    assign in_handler     = r_in_handler;
    assign misalign_err   = r_misalign;

endmodule
`default_nettype wire
